alu_result_fifo: RTL and testbench

//  Downstream stage of the combinational ALU: captures each ALU result (WIDTH+1 bits)

---
 rtl/alu_result_fifo.sv | 132 +++++++++++++
 tb/tb_alu_result_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_fifo
// Description : Buffers ALU results with opcode and derived carry/zero/neg
//               flags in a DEPTH-entry FIFO behind valid/ready handshakes.
//               Optional feature macro: ALU_STICKY_FLAGS_EN (sticky carry).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_sel,
  input  logic [WIDTH:0]           in_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [2:0]               out_op,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic                     out_neg,
`ifdef ALU_STICKY_FLAGS_EN
  input  logic                     sticky_clr,
  output logic                     sticky_carry,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

  logic [WIDTH-1:0]   r_data_mem  [DEPTH];
  logic [2:0]         r_op_mem    [DEPTH];
  logic [DEPTH-1:0]   r_carry_mem;
  logic [DEPTH-1:0]   r_zero_mem;
  logic [DEPTH-1:0]   r_neg_mem;

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_carry_in;
  logic               w_zero_in;
  logic               w_neg_in;

  // Full FIFO blocks pushes even when a pop frees a slot in the same cycle.
  assign w_full    = (r_count == c_FULL);
  assign in_ready  = ~rst & ~w_full;
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Bit WIDTH is only meaningful as carry/borrow for add (000) and sub (001).
  assign w_carry_in = (in_sel[2:1] == 2'b00) ? in_result[WIDTH] : 1'b0;
  assign w_zero_in  = ~|in_result[WIDTH-1:0];
  assign w_neg_in   = in_result[WIDTH-1];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data_mem[r_wr_ptr]  <= in_result[WIDTH-1:0];
      r_op_mem[r_wr_ptr]    <= in_sel;
      r_carry_mem[r_wr_ptr] <= w_carry_in;
      r_zero_mem[r_wr_ptr]  <= w_zero_in;
      r_neg_mem[r_wr_ptr]   <= w_neg_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Stale memory contents never leak: head fields are masked when empty.
  always_comb begin
    out_data  = '0;
    out_op    = '0;
    out_carry = 1'b0;
    out_zero  = 1'b0;
    out_neg   = 1'b0;
    if (out_valid) begin
      out_data  = r_data_mem[r_rd_ptr];
      out_op    = r_op_mem[r_rd_ptr];
      out_carry = r_carry_mem[r_rd_ptr];
      out_zero  = r_zero_mem[r_rd_ptr];
      out_neg   = r_neg_mem[r_rd_ptr];
    end
  end

  assign count = r_count;

`ifdef ALU_STICKY_FLAGS_EN
  logic r_sticky_carry;

  // Setting on a carry pop takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky_carry <= 1'b0;
    end else if (w_pop && out_carry) begin
      r_sticky_carry <= 1'b1;
    end else if (sticky_clr) begin
      r_sticky_carry <= 1'b0;
    end
  end

  assign sticky_carry = r_sticky_carry;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_fifo
// Description : Self-checking bench for alu_result_fifo against a queue model;
//               covers sticky carry when ALU_STICKY_FLAGS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_fifo;

  localparam int W = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic [2:0]   op;
    logic         c;
    logic         z;
    logic         n;
  } ent_t;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [2:0]              in_sel;
  logic [W:0]              in_result;
  logic                    out_valid;
  logic                    out_ready;
  logic [W-1:0]            out_data;
  logic [2:0]              out_op;
  logic                    out_carry;
  logic                    out_zero;
  logic                    out_neg;
  logic [$clog2(DEPTH):0]  count;
`ifdef ALU_STICKY_FLAGS_EN
  logic                    sticky_clr;
  logic                    sticky_carry;
  logic                    m_sticky;
`endif

  ent_t model[$];
  int   n_chk;
  int   n_fail;

  alu_result_fifo #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sel       (in_sel),
    .in_result    (in_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_op       (out_op),
    .out_carry    (out_carry),
    .out_zero     (out_zero),
    .out_neg      (out_neg),
`ifdef ALU_STICKY_FLAGS_EN
    .sticky_clr   (sticky_clr),
    .sticky_carry (sticky_carry),
`endif
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = model.size();
    chk("count", 32'(count), 32'(sz));
    chk("in_ready", 32'(in_ready), 32'(!rst && sz < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(sz != 0));
    if (sz != 0) begin
      chk("out_data", 32'(out_data), 32'(model[0].data));
      chk("out_op", 32'(out_op), 32'(model[0].op));
      chk("out_carry", 32'(out_carry), 32'(model[0].c));
      chk("out_zero", 32'(out_zero), 32'(model[0].z));
      chk("out_neg", 32'(out_neg), 32'(model[0].n));
    end else begin
      chk("empty_fields", {17'd0, out_data, out_op, out_carry, out_zero, out_neg}, 32'd0);
    end
`ifdef ALU_STICKY_FLAGS_EN
    chk("sticky_carry", 32'(sticky_carry), 32'(m_sticky));
`endif
  endtask

  // One clock: drive inputs, check, advance the model at the edge.
  task automatic cycle(input logic v, input logic [2:0] s, input logic [W:0] r, input logic ordy);
    logic push, pop;
    ent_t e;
    in_valid = v; in_sel = s; in_result = r; out_ready = ordy;
    #1;
    check_outputs();
    push = v && (model.size() < DEPTH);
    pop  = ordy && (model.size() > 0);
    @(posedge clk);
`ifdef ALU_STICKY_FLAGS_EN
    if (pop && model[0].c) m_sticky = 1'b1;
    else if (sticky_clr)   m_sticky = 1'b0;
`endif
    if (pop) e = model.pop_front();
    if (push) begin
      e.data = r[W-1:0];
      e.op   = s;
      e.c    = (s == 3'd0 || s == 3'd1) ? r[W] : 1'b0;
      e.z    = (r[W-1:0] == 0);
      e.n    = r[W-1];
      model.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b1; in_sel = 3'd0; in_result = 9'h1AA; out_ready = 1'b1;
    #1;
    chk("in_ready_in_rst", 32'(in_ready), 32'd0);
    @(posedge clk);
    model.delete();
`ifdef ALU_STICKY_FLAGS_EN
    m_sticky = 1'b0;
`endif
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check_outputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clk = 1'b0; rst = 1'b1;
    in_valid = 1'b0; in_sel = '0; in_result = '0; out_ready = 1'b0;
    n_chk = 0; n_fail = 0;
`ifdef ALU_STICKY_FLAGS_EN
    sticky_clr = 1'b0; m_sticky = 1'b0;
`endif
    @(negedge clk);
    do_reset();

    // Add with carry out, then logic op whose bit 8 must be ignored.
    cycle(1, 3'b000, 9'h105, 0);
    chk("t1_data", 32'(out_data), 32'h05);
    chk("t1_carry", 32'(out_carry), 32'd1);
    cycle(0, 3'b000, 9'h000, 1);
    cycle(1, 3'b010, 9'h100, 0);
    chk("t2_carry", 32'(out_carry), 32'd0);
    chk("t2_zero", 32'(out_zero), 32'd1);
    cycle(0, 3'b000, 9'h000, 1);

    // Fill while stalled, attempt a fifth push, drain in order.
    for (int i = 0; i < 5; i++) cycle(1, 3'(i), 9'(9'h0F0 + 9'(i * 9'h21)), 0);
    chk("t3_full_count", 32'(count), 32'(DEPTH));
    for (int i = 0; i < 5; i++) cycle(0, 3'd0, 9'h0, 1);

    // Hold count at 2 with simultaneous push and pop across pointer wrap.
    cycle(1, 3'b001, 9'h1FE, 0);
    cycle(1, 3'b011, 9'h080, 0);
    for (int i = 0; i < 10; i++) cycle(1, 3'(i), 9'(i * 37 + 3), 1);
    chk("t4_count", 32'(count), 32'd2);

    // Reset while holding three entries.
    cycle(1, 3'b100, 9'h0C3, 0);
    chk("t5_pre_count", 32'(count), 32'd3);
    do_reset();

`ifdef ALU_STICKY_FLAGS_EN
    cycle(1, 3'b001, 9'h1FF, 0);
    cycle(1, 3'b000, 9'h180, 1);
    chk("t6_set", 32'(sticky_carry), 32'd1);
    sticky_clr = 1'b1;
    cycle(0, 3'b000, 9'h000, 1);
    chk("t6_set_wins", 32'(sticky_carry), 32'd1);
    cycle(0, 3'b000, 9'h000, 0);
    chk("t6_clr", 32'(sticky_carry), 32'd0);
    sticky_clr = 1'b0;
`endif

    // Randomised traffic with varying backpressure and occasional resets.
    for (int i = 0; i < 600; i++) begin
      int rp;
      rp = (i / 100) % 3;
`ifdef ALU_STICKY_FLAGS_EN
      sticky_clr = ($urandom_range(0, 7) == 0);
`endif
      if (i % 157 == 156) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
              9'($urandom), $urandom_range(0, rp + 1) != 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
